// File: rtl/full_adder_df.sv
// Registered ripple-carry adder built from per-bit dataflow full-adder cells.
// Optional macro FULL_ADDER_DF_OVF_EN adds a registered signed-overflow output 'ovf'.

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module full_adder_df #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef FULL_ADDER_DF_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  // Carry ripples bit 0 -> WIDTH-1 through the cell chain; no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        carry <= c[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_DF_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf <= 1'b0;
    else if (in_valid) ovf <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_full_adder_df.sv
// Scoreboarded bench: a WIDTH=4 and a WIDTH=1 adder share valid/cin and are
// checked against an integer-arithmetic reference model.

module tb_full_adder_df;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin = 1'b0, inv = 1'b0;
  logic [3:0] sum4;
  logic       carry4, ov4;
  logic [0:0] sum1;
  logic       carry1, ov1;
  logic       ovf4, ovf1;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  typedef struct {
    logic [3:0] s4;
    logic       c4, o4, s1, c1, o1;
  } exp_t;

  exp_t q[$];
  exp_t last;

  always #5 clk = ~clk;

  full_adder_df #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin), .in_valid(inv),
    .sum(sum4), .carry(carry4),
`ifdef FULL_ADDER_DF_OVF_EN
    .ovf(ovf4),
`endif
    .out_valid(ov4)
  );

  full_adder_df #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a4[0:0]), .b(b4[0:0]), .cin(cin), .in_valid(inv),
    .sum(sum1), .carry(carry1),
`ifdef FULL_ADDER_DF_OVF_EN
    .ovf(ovf1),
`endif
    .out_valid(ov1)
  );

`ifndef FULL_ADDER_DF_OVF_EN
  assign ovf4 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  // Reference: unsigned sum split into {carry,sum}; overflow from the signed
  // result falling outside the representable range.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic ci);
    exp_t e;
    int u4, u1, sa, sb, r;
    u4 = int'(a) + int'(b) + int'(ci);
    e.s4 = u4[3:0];
    e.c4 = u4[4];
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    r  = sa + sb + int'(ci);
    e.o4 = (r > 7) || (r < -8);
    u1 = int'(a[0]) + int'(b[0]) + int'(ci);
    e.s1 = u1[0];
    e.c1 = u1[1];
    r  = (a[0] ? -1 : 0) + (b[0] ? -1 : 0) + int'(ci);
    e.o1 = (r > 0) || (r < -1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
    @(posedge clk);
    #1;
    a4 = a; b4 = b; cin = ci; inv = v;
    if (v) q.push_back(model(a, b, ci));
  endtask

  // Monitor: pop on out_valid, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("vld_w1_vs_w4", {7'd0, ov1}, {7'd0, ov4});
      if (ov4) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {7'd0, ov4}, 8'd0);
        end else begin
          last = q.pop_front();
          chk("sum4", {4'd0, sum4}, {4'd0, last.s4});
          chk("carry4", {7'd0, carry4}, {7'd0, last.c4});
          chk("sum1", {7'd0, sum1}, {7'd0, last.s1});
          chk("carry1", {7'd0, carry1}, {7'd0, last.c1});
`ifdef FULL_ADDER_DF_OVF_EN
          chk("ovf4", {7'd0, ovf4}, {7'd0, last.o4});
          chk("ovf1", {7'd0, ovf1}, {7'd0, last.o1});
`endif
        end
      end else begin
        chk("hold_sum4", {4'd0, sum4}, {4'd0, last.s4});
        chk("hold_carry4", {7'd0, carry4}, {7'd0, last.c4});
        chk("hold_sum1", {7'd0, sum1}, {7'd0, last.s1});
        chk("hold_carry1", {7'd0, carry1}, {7'd0, last.c1});
`ifdef FULL_ADDER_DF_OVF_EN
        chk("hold_ovf4", {7'd0, ovf4}, {7'd0, last.o4});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_expect();
    q.delete();
    last = '{s4: 4'd0, c4: 1'b0, o4: 1'b0, s1: 1'b0, c1: 1'b0, o1: 1'b0};
  endtask

  initial begin
    clear_expect();
    #12;
    chk("rst_sum4", {4'd0, sum4}, 8'd0);
    chk("rst_carry4", {7'd0, carry4}, 8'd0);
    chk("rst_vld4", {7'd0, ov4}, 8'd0);
    chk("rst_vld1", {7'd0, ov1}, 8'd0);
    @(posedge clk); #1 rst = 1'b0;
    started = 1;

    // Single-bit cases (low bit) and full 8-combination sweep
    drive(4'h1, 4'h0, 1'b0, 1'b1);
    drive(4'h0, 4'h1, 1'b0, 1'b1);
    drive(4'h1, 4'h1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive({3'($urandom_range(0, 7)), v[2]}, {3'($urandom_range(0, 7)), v[1]}, v[0], 1'b1);
    end

    // 4-bit boundaries
    drive(4'hF, 4'h1, 1'b0, 1'b1);
    drive(4'hF, 4'hF, 1'b1, 1'b1);
    drive(4'h0, 4'h0, 1'b0, 1'b1);

    // Signed overflow cases
    drive(4'h7, 4'h1, 1'b0, 1'b1);
    drive(4'h8, 4'h8, 1'b0, 1'b1);
    drive(4'h3, 4'h2, 1'b0, 1'b1);

    // Hold: result 5, then three idle cycles with junk operands
    drive(4'h2, 4'h3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(4'hA, 4'hA, 1'bx, 1'b0);

    // Async reset between edges while a nonzero result is valid
    drive(4'h9, 4'h4, 1'b0, 1'b1);
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum4", {4'd0, sum4}, 8'd0);
    chk("async_rst_carry4", {7'd0, carry4}, 8'd0);
    chk("async_rst_vld4", {7'd0, ov4}, 8'd0);
    chk("async_rst_sum1", {7'd0, sum1}, 8'd0);
    clear_expect();
    @(posedge clk); #1 rst = 1'b0;
    drive(4'h6, 4'h3, 1'b1, 1'b1);

    // Randomized traffic with mixed valid density
    for (int i = 0; i < 300; i++)
      drive(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));

    drive(4'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder_df.md
Name: full_adder_df

Overview:
- Parameterised ripple-carry full adder built from per-bit dataflow full-adder cells.
- Output is registered: one clock of latency, with a valid qualifier.
- Leaf arithmetic primitive for datapaths needing a registered add with carry-in and carry-out.
- With WIDTH=1 it is the classic single-bit full adder (a, b, cin -> sum, carry).

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry into bit 0.
- in_valid  input  1  operands valid this cycle; capture on clk rise.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  sum/carry updated from a valid capture in the previous cycle.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Per-bit cell, pure dataflow (continuous assignments, no procedural logic in the cell):
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = cin
- The carry chain ripples bit 0 -> bit WIDTH-1 combinationally. No lookahead.
- Arithmetic: {carry, sum} = a + b + cin, WIDTH+1 bits, unsigned. No truncation other than the output split.
- Output register:
  - On rising clk with in_valid=1: sum<=s, carry<=c[WIDTH], out_valid<=1.
  - On rising clk with in_valid=0: sum and carry hold their previous values; out_valid<=0.
- Latency is exactly 1 cycle; throughput is 1 operation per cycle. Back-to-back valids produce back-to-back out_valid.
- Reset:
  - rst=1 immediately forces sum=0, carry=0, out_valid=0, independent of clk.
  - Reset asserted mid-operation discards the in-flight result.
  - The first capture after release occurs on the first rising clk with rst=0 and in_valid=1.
- Unknown inputs:
  - With in_valid=0, a, b and cin are don't-care and must not disturb the outputs.
  - With in_valid=1, X/Z on any operand may propagate to sum/carry. No X-masking is performed.
- Boundaries:
  - All-ones a and b with cin=1 gives sum = all ones, carry=1.
  - All-zeros with cin=0 gives sum=0, carry=0.
- No backpressure: the output is overwritten by the next valid capture.

Optional Feature:
- Macro: FULL_ADDER_DF_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = c[WIDTH] ^ c[WIDTH-1], the signed two's-complement overflow.
  - ovf is registered with the same enable, hold and reset rules as carry; reset value 0.
  - For WIDTH=1, c[WIDTH-1] is cin.
- Undefined: the ovf port and its logic are absent entirely. All other behaviour is identical.

Test Plan:
- WIDTH=1, reset, then in_valid=1 with a=1, b=0, cin=0 -> next cycle sum=1, carry=0, out_valid=1.
- WIDTH=1: a=0, b=1, cin=0 -> sum=1, carry=0. Then a=1, b=1, cin=1 -> sum=1, carry=1. Also sweep all 8 input combinations against a+b+cin.
- WIDTH=4: a=4'hF, b=4'h1, cin=0 -> sum=4'h0, carry=1. Then a=4'hF, b=4'hF, cin=1 -> sum=4'hF, carry=1. Then a=0, b=0, cin=0 -> sum=0, carry=0.
- Hold: after a valid result sum=4'h5, drive in_valid=0 with a=4'hA, b=4'hA and cin=X for 3 cycles -> sum stays 4'h5, carry unchanged, out_valid=0.
- Async reset: assert rst between clock edges while out_valid=1 and sum nonzero -> sum=0, carry=0, out_valid=0 immediately. After release, the next valid input is captured normally.
- With FULL_ADDER_DF_OVF_EN defined, WIDTH=4: a=4'h7, b=4'h1, cin=0 -> sum=4'h8, ovf=1. Then a=4'h8, b=4'h8, cin=0 -> sum=0, carry=1, ovf=1. Then a=4'h3, b=4'h2, cin=0 -> ovf=0.
